systolic_array_mn: RTL and testbench
====================================

# systolic_array_mn

Parametrised output-stationary ROWS×COLS systolic matrix-multiply core. Successor to the square N×N array: non-square geometry, a runtime reduction length, valid/ready handshakes on both sides, and a row-parallel result drain with backpressure. It accepts one column of A and one row of B per beat, accumulates C = A·B in place, then streams C out one row per handshake. It sits between the operand streamers and the result writeback.

## Interface
- DIN_WIDTH, 8: signed operand width.
- ROWS, 4: array rows; the A vector length.
- COLS, 4: array columns; the B vector length.
- K_MAX, 16: maximum beats per matrix product.
- OUT_WIDTH, 2*DIN_WIDTH: signed result width.
- Accumulator width ACC_WIDTH = 2*DIN_WIDTH + $clog2(K_MAX), derived, not overridable.
- clk  in  1  single clock; all flops are rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  [ROWS][DIN_WIDTH] signed  A column for the current beat.
- b  in  [COLS][DIN_WIDTH] signed  B row for the current beat.
- in_valid  in  1  beat present.
- in_last  in  1  final beat of the product.
- in_ready  out  1  core accepts a beat.
- c_dout  out  [COLS][OUT_WIDTH] signed  one result row.
- c_dout_row  out  $clog2(ROWS)  row index of c_dout.
- out_valid  out  1  c_dout is valid.
- out_ready  in  1  sink accepts the row.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: in_ready=1. The first accepted beat clears all accumulators, enters the array, sets beat count to 1, and moves to LOAD. If that beat has in_last, the FSM moves to FLUSH instead.
- LOAD: in_ready=1. On each accepted beat, beat count increments. The FSM moves to FLUSH on in_last, or when the count reaches K_MAX (forced last). in_valid=0 inserts a bubble: zeros are injected and accumulators are unchanged.
- FLUSH: in_ready=0. Zeros are injected for ROWS+COLS-1 cycles so the skewed wavefront reaches every PE. The FSM then moves to DRAIN.
- DRAIN: in_ready=0, out_valid=1. c_dout_row starts at 0 and advances on out_valid&&out_ready. The handshake on row ROWS-1 returns the FSM to IDLE.
- Skew: a[i] is delayed i cycles and b[j] is delayed j cycles before entering the array. Operands propagate right (A) and down (B) one PE per cycle.
- PE(i,j): acc += a·b at full precision. acc is wrapped at ACC_WIDTH, which cannot overflow for up to K_MAX beats.
- Output conversion from ACC_WIDTH to OUT_WIDTH is set by the Configuration macro.
- c_dout, c_dout_row: held stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 while rst_n is low and 1 in the first cycle after release. out_valid=0, c_dout=0, c_dout_row=0. FSM is IDLE; all accumulators, skew registers and the beat count are 0.
- Throughput: one beat per cycle in LOAD.
- Latency: out_valid rises exactly ROWS+COLS cycles after the cycle the last beat is accepted (one transition cycle plus ROWS+COLS-1 FLUSH cycles).
- in_valid while in_ready=0 is ignored, and the data is not consumed.
- in_last on a beat that also reaches K_MAX is a single last; there is no double transition.
- out_ready held at 1 drains all rows in ROWS consecutive cycles.
- After the last row's handshake, in_ready=1 on the next cycle.
- Reset mid-operation, in any state, aborts immediately to the reset values. The partial product is discarded.

## Configuration
- SYSTOLIC_SAT_EN defined: each result saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- SYSTOLIC_SAT_EN undefined: each result takes the low OUT_WIDTH bits of the accumulator (two's-complement wrap).

## Structure
- Package systolic_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN);
  - a function computing ACC_WIDTH from DIN_WIDTH and K_MAX;
  - the saturate/truncate conversion function.
- Sub-module systolic_pe: one multiply-accumulate cell with an A pass-through register, a B pass-through register, a clear input and an enable input.
- The top level holds the skew registers, the FSM, the beat counter, the ROWS×COLS PE array and the row output mux.

## Test plan
All scenarios use ROWS=COLS=4, DIN=8, K_MAX=16.
- Identity: A=I (4 beats, in_last on beat 4), B rows = {1,2,3,4}·k for k=1..4. Expect rows {1,2,3,4}, {2,4,6,8}, {3,6,9,12}, {4,8,12,16}, with out_valid exactly 8 cycles after the last beat.
- K=1: a single beat with in_last, a={1,-2,3,-4}, b={5,6,7,8}. Expect c[i][j]=a[i]·b[j], e.g. row 1 = {-10,-12,-14,-16}.
- Forced last: 16 beats of all-ones, in_last never asserted. Expect FLUSH after beat 16 and every result = 16.
- Saturation: 16 beats of a=b=-128. With SYSTOLIC_SAT_EN, every result = 32767. Without it, every result = 0 (262144 mod 2^16).
- Backpressure: out_ready toggles 1,0,0,1,... during DRAIN. Expect c_dout and c_dout_row stable while stalled, and rows 0..3 each delivered exactly once.
- Reset mid-DRAIN: drop rst_n after row 1. Expect out_valid=0 immediately. After release, a new K=1 product must produce correct results, with no stale accumulator data.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic_array_mn matrix-multiply core.
// Build option: SYSTOLIC_SAT_EN selects saturating result conversion instead of wrap.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int CONV_W = 64;

    // Products need 2*din bits; each doubling of the beat count adds one more.
    function automatic int acc_width(input int din_width, input int k_max);
        return 2 * din_width + $clog2(k_max);
    endfunction

    // Narrows a sign-extended accumulator to out_w bits; the result is returned sign-extended.
    function automatic logic signed [CONV_W-1:0] conv_result(input logic signed [CONV_W-1:0] acc,
                                                             input int out_w);
`ifdef SYSTOLIC_SAT_EN
        logic signed [CONV_W-1:0] hi;
        logic signed [CONV_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return (acc <<< (CONV_W - out_w)) >>> (CONV_W - out_w);
`endif
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell: forwards A right and B down by one cycle,
// accumulating a*b; clr_i restarts the sum with the current product.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr_i,
    input  logic                        en_i,
    input  logic [DIN_WIDTH-1:0]        a_i,
    input  logic [DIN_WIDTH-1:0]        b_i,
    output logic [DIN_WIDTH-1:0]        a_o,
    output logic [DIN_WIDTH-1:0]        b_o,
    output logic signed [ACC_WIDTH-1:0] acc_o
);

    logic [DIN_WIDTH-1:0]        a_q;
    logic [DIN_WIDTH-1:0]        b_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [2*DIN_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_d    = clr_i ? prod_ext : acc_q + prod_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (en_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_array_mn.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with skewed operand entry and row drain.
// Build option: SYSTOLIC_SAT_EN (see systolic_pkg::conv_result).
module systolic_array_mn
    import systolic_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_MAX     = 16,
    parameter int OUT_WIDTH = 2 * DIN_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ROWS-1:0][DIN_WIDTH-1:0]   a,
    input  logic [COLS-1:0][DIN_WIDTH-1:0]   b,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [COLS-1:0][OUT_WIDTH-1:0]   c_dout,
    output logic [$clog2(ROWS)-1:0]          c_dout_row,
    output logic                             out_valid,
    input  logic                             out_ready,
    output state_e                           dbg_state_o
);

    localparam int ACC_WIDTH = acc_width(DIN_WIDTH, K_MAX);
    localparam int RW        = $clog2(ROWS);
    localparam int BW        = $clog2(K_MAX + 1);
    localparam int FW        = $clog2(ROWS + COLS);

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [RW-1:0]   row_q;
    logic [BW-1:0]   beat_cnt_q;
    logic [FW-1:0]   flush_cnt_q;

    logic accept;
    logic pe_clr;
    logic pe_en;

    logic [DIN_WIDTH-1:0]        a_h [ROWS][COLS];
    logic [DIN_WIDTH-1:0]        b_v [ROWS][COLS];
    logic signed [ACC_WIDTH-1:0] acc [ROWS][COLS];
    logic signed [CONV_W-1:0]    conv_tmp;

    assign accept = in_valid && in_ready_q;
    assign pe_clr = accept && (state_q == IDLE);
    assign pe_en  = (state_q != DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            row_q       <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        beat_cnt_q <= BW'(1);
                        if (in_last || K_MAX == 1) begin
                            state_q     <= FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= '0;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                        // A beat that is both flagged last and the K_MAX-th is one transition.
                        if (in_last || beat_cnt_q == BW'(K_MAX - 1)) begin
                            state_q     <= FLUSH;
                            in_ready_q  <= 1'b0;
                            flush_cnt_q <= '0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == FW'(ROWS + COLS - 2)) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_q == RW'(ROWS - 1)) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            row_q       <= '0;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Row i of A enters i cycles late and column j of B j cycles late, so matching k meet in PE(i,j).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DIN_WIDTH-1:0] a_inj;
        assign a_inj = accept ? a[i] : '0;
        if (i == 0) begin : g_direct
            assign a_h[i][0] = a_inj;
        end else begin : g_dly
            logic [DIN_WIDTH-1:0] sr_q [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= a_inj;
                    for (int k = 1; k < i; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign a_h[i][0] = sr_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DIN_WIDTH-1:0] b_inj;
        assign b_inj = accept ? b[j] : '0;
        if (j == 0) begin : g_direct
            assign b_v[0][j] = b_inj;
        end else begin : g_dly
            logic [DIN_WIDTH-1:0] sr_q [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < j; k++) sr_q[k] <= '0;
                end else begin
                    sr_q[0] <= b_inj;
                    for (int k = 1; k < j; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign b_v[0][j] = sr_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DIN_WIDTH-1:0] a_nxt;
            logic [DIN_WIDTH-1:0] b_nxt;
            systolic_pe #(
                .DIN_WIDTH (DIN_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clr_i (pe_clr),
                .en_i  (pe_en),
                .a_i   (a_h[i][j]),
                .b_i   (b_v[i][j]),
                .a_o   (a_nxt),
                .b_o   (b_nxt),
                .acc_o (acc[i][j])
            );
            if (j < COLS - 1) begin : g_a_fwd
                assign a_h[i][j+1] = a_nxt;
            end else begin : g_a_end
                logic [DIN_WIDTH-1:0] a_tail_unused;
                assign a_tail_unused = a_nxt;
            end
            if (i < ROWS - 1) begin : g_b_fwd
                assign b_v[i+1][j] = b_nxt;
            end else begin : g_b_end
                logic [DIN_WIDTH-1:0] b_tail_unused;
                assign b_tail_unused = b_nxt;
            end
        end
    end

    // Accumulators are frozen during DRAIN, so the selected row stays stable under backpressure.
    always_comb begin
        c_dout   = '0;
        conv_tmp = '0;
        if (out_valid_q) begin
            for (int j = 0; j < COLS; j++) begin
                conv_tmp  = conv_result(CONV_W'(acc[row_q][j]), OUT_WIDTH);
                c_dout[j] = conv_tmp[OUT_WIDTH-1:0];
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign c_dout_row  = row_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_array_mn.sv
// Scoreboard bench for systolic_array_mn (4x4, 8-bit operands, K_MAX=16).
module tb_systolic_array_mn;
    import systolic_pkg::*;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int KM = 16;
    localparam int OW = 16;
    localparam int RW = 2;
    localparam int W  = RW + C * OW;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [R-1:0][DW-1:0] a;
    logic [C-1:0][DW-1:0] b;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [C-1:0][OW-1:0] c_dout;
    logic [RW-1:0]        c_dout_row;
    logic                 out_valid;
    logic                 out_ready;
    state_e               dbg_state;

    systolic_array_mn #(
        .DIN_WIDTH (DW),
        .ROWS      (R),
        .COLS      (C),
        .K_MAX     (KM),
        .OUT_WIDTH (OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .c_dout      (c_dout),
        .c_dout_row  (c_dout_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbg_state_o (dbg_state)
    );

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic         bp_mode  = 1'b0;
    logic [3:0]   bp_pat   = 4'b1001;
    int           bp_idx   = 0;
    int           m [4][4];

    task automatic check(input string name, input logic ok, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic push_rows();
        logic [C-1:0][OW-1:0] rv;
        for (int r = 0; r < R; r++) begin
            for (int j = 0; j < C; j++) rv[j] = OW'(m[r][j]);
            exp_q.push_back({RW'(r), rv});
        end
    endtask

    // driver tasks: entered and left at posedge+1
    task automatic send_beat(input int av[4], input int bv[4], input logic last);
        logic got;
        int   guard;
        for (int i = 0; i < R; i++) a[i] = DW'(av[i]);
        for (int j = 0; j < C; j++) b[j] = DW'(bv[j]);
        in_valid = 1'b1;
        in_last  = last;
        guard    = 0;
        forever begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) break;
            guard++;
            if (guard > 50) begin
                check("beat_accept_timeout", 1'b0, W'(0), W'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = '0;
        b        = '0;
    endtask

    task automatic wait_drain();
        int   guard;
        logic seen;
        guard = 0;
        seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else if (seen) break;
            guard++;
            if (guard > 200) break;
        end
        check("drain_done", seen && !out_valid, W'(out_valid), W'(0));
        check("ready_after_drain", in_ready, W'(in_ready), W'(1));
        check("rows_once", exp_q.size() == 0, W'(exp_q.size()), W'(0));
        @(posedge clk);
        #1;
    endtask

    // out_ready: 1 normally, pattern 1,0,0,1 during DRAIN in backpressure mode
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode && out_valid) begin
                out_ready = bp_pat[bp_idx % 4];
                bp_idx++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 1'b0, {c_dout_row, c_dout}, W'(0));
                end else begin
                    check("row_data", {c_dout_row, c_dout} == exp_q[0], {c_dout_row, c_dout}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int av[4];
        int bv[4];
        int lat;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", !in_ready, W'(in_ready), W'(0));
        check("rst_out_valid", !out_valid, W'(out_valid), W'(0));
        check("rst_c_dout", c_dout == '0, W'(c_dout), W'(0));
        check("rst_row", c_dout_row == '0, W'(c_dout_row), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", in_ready, W'(in_ready), W'(1));
        check("idle_after_rst", dbg_state == IDLE, W'(dbg_state), W'(IDLE));

        // identity A, B rows {1,2,3,4}*k, plus latency and ignored beats while flushing
        m = '{'{1, 2, 3, 4}, '{2, 4, 6, 8}, '{3, 6, 9, 12}, '{4, 8, 12, 16}};
        push_rows();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) av[i] = (i == k) ? 1 : 0;
            for (int j = 0; j < 4; j++) bv[j] = (j + 1) * (k + 1);
            send_beat(av, bv, k == 3);
        end
        in_valid = 1'b1;
        a        = {R{8'h07}};
        b        = {C{8'h07}};
        lat      = 0;
        do begin
            lat++;
            @(negedge clk);
            if (lat == 1) check("flush_not_ready", !in_ready, W'(in_ready), W'(0));
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        check("latency", lat == R + C, W'(lat), W'(R + C));
        wait_drain();

        // single beat: outer product
        m = '{'{5, 6, 7, 8}, '{-10, -12, -14, -16}, '{15, 18, 21, 24}, '{-20, -24, -28, -32}};
        push_rows();
        send_beat('{1, -2, 3, -4}, '{5, 6, 7, 8}, 1'b1);
        wait_drain();

        // forced last after K_MAX beats of ones
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) m[r][j] = 16;
        push_rows();
        for (int k = 0; k < KM; k++) send_beat('{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0);
        check("forced_flush", dbg_state == FLUSH, W'(dbg_state), W'(FLUSH));
        check("forced_not_ready", !in_ready, W'(in_ready), W'(0));
        wait_drain();

        // -128*-128 over 16 beats, last coincides with K_MAX
        for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) begin
`ifdef SYSTOLIC_SAT_EN
            m[r][j] = 32767;
`else
            m[r][j] = 0;
`endif
        end
        push_rows();
        for (int k = 0; k < KM; k++)
            send_beat('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, k == KM - 1);
        check("sat_flush", dbg_state == FLUSH, W'(dbg_state), W'(FLUSH));
        wait_drain();

        // two beats with a bubble, drained under backpressure
        m = '{'{3, 1, 0, 2}, '{1, -1, 4, 0}, '{7, 1, 4, 4}, '{-1, -3, 8, -2}};
        push_rows();
        bp_mode = 1'b1;
        bp_idx  = 0;
        send_beat('{1, 0, 2, -1}, '{3, 1, 0, 2}, 1'b0);
        @(posedge clk);
        #1;
        send_beat('{0, 1, 1, 2}, '{1, -1, 4, 0}, 1'b1);
        wait_drain();
        bp_mode = 1'b0;

        // reset after row 1 of a drain, then a fresh product
        m = '{'{5, 6, 7, 8}, '{-10, -12, -14, -16}, '{15, 18, 21, 24}, '{-20, -24, -28, -32}};
        push_rows();
        send_beat('{1, -2, 3, -4}, '{5, 6, 7, 8}, 1'b1);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if ((out_valid && out_ready && c_dout_row == RW'(1)) || lat > 60) break;
        end
        check("row1_reached", lat <= 60, W'(lat), W'(60));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", !out_valid, W'(out_valid), W'(0));
        check("mid_rst_in_ready", !in_ready, W'(in_ready), W'(0));
        check("mid_rst_row", c_dout_row == '0, W'(c_dout_row), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m = '{'{-6, 8, 2, -4}, '{-9, 12, 3, -6}, '{3, -4, -1, 2}, '{-3, 4, 1, -2}};
        push_rows();
        send_beat('{2, 3, -1, 1}, '{-3, 4, 1, -2}, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
